// File: rtl/instr_fetch.sv
// instr_fetch: MIPS IF stage (fetch PC, IF/ID, skid, delay-slot redirects); IFETCH_ALIGN_CHECK_EN adds JR misalignment fault
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        jump_branch,
  input  logic        jump_target,
  input  logic        jump_reg,
  input  logic [31:0] jr_pc,
  output logic [31:0] pc_id,
  output logic [31:0] instr_id,
  output logic        valid_id
`ifdef IFETCH_ALIGN_CHECK_EN
  ,
  output logic        fault_misaligned
`endif
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
  state_t st, st_nx;
  logic [31:0] fetch_pc, req_pc, sk_pc, sk_instr, pend_tgt, slot_pc, tgt;
  logic sk_valid, pend_valid, held, rsp, ld, redir, defer, now, acc, halt, stop;
  // redirect target and whether the delay slot is still to be requested (defer) or already out (now)
  always_comb begin
    slot_pc = pc_id + 32'd4;
    tgt = jump_reg ? (jr_pc & ~32'd3)
        : jump_target ? {slot_pc[31:28], instr_id[25:0], 2'b00}
        : slot_pc + {{14{instr_id[15]}}, instr_id[15:0], 2'b00};
    rsp = (st == S_WAIT) & imem_rsp_valid;
    ld = ~valid_id | ~stall;
    redir = valid_id & ~stall & (jump_reg | jump_target | jump_branch);
    defer = redir & ((fetch_pc == slot_pc) | held);
    now = redir & ~defer;
  end
  // request outputs; a fresh request after a resolved redirect goes straight to the target
  always_comb begin
    imem_req_addr = now ? tgt : fetch_pc;
    imem_req_valid = ~rst & ~halt & ~stop & ((st == S_REQ) | (rsp & ld));
    acc = imem_req_valid & imem_req_ready;
  end
  // next-state logic
  always_comb begin
    st_nx = (st == S_REQ) ? (halt ? S_HOLD : acc ? S_WAIT : S_REQ)
          : (st == S_WAIT) ? (~imem_rsp_valid ? S_WAIT : ~ld ? S_HOLD : acc ? S_WAIT : S_REQ)
          : (ld & ~halt) ? S_REQ : S_HOLD;
  end
  // state register
  always_ff @(posedge clk) begin
    st <= rst ? S_REQ : st_nx;
  end
  // fetch PC, pending redirect, IF/ID register and skid buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc <= RESET_PC;
      pend_valid <= 1'b0;
      pend_tgt <= 32'd0;
      held <= 1'b0;
      valid_id <= 1'b0;
      pc_id <= 32'd0;
      instr_id <= 32'd0;
      sk_valid <= 1'b0;
      sk_pc <= 32'd0;
      sk_instr <= 32'd0;
    end else begin
      if (acc) begin
        req_pc <= imem_req_addr;
        fetch_pc <= defer ? tgt : pend_valid ? pend_tgt : imem_req_addr + 32'd4;
        pend_valid <= 1'b0;
      end else if (now) begin
        fetch_pc <= tgt;
      end else if (defer) begin
        pend_valid <= 1'b1;
        pend_tgt <= tgt;
      end
      held <= imem_req_valid & ~imem_req_ready;
      if (ld) begin
        valid_id <= sk_valid | rsp;
        pc_id <= sk_valid ? sk_pc : rsp ? req_pc : pc_id;
        instr_id <= sk_valid ? sk_instr : rsp ? imem_rsp_data : 32'd0;
        sk_valid <= 1'b0;
      end else if (rsp) begin
        sk_valid <= 1'b1;
        sk_pc <= req_pc;
        sk_instr <= imem_rsp_data;
      end
    end
  end
`ifdef IFETCH_ALIGN_CHECK_EN
  logic bad, pend_halt;
  assign bad = jump_reg & (jr_pc[1:0] != 2'b00);
  assign stop = now & bad;
  // sticky fault; fetching halts once the delay slot of a misaligned JR has been requested
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_misaligned <= 1'b0;
      halt <= 1'b0;
      pend_halt <= 1'b0;
    end else begin
      if (redir & bad) fault_misaligned <= 1'b1;
      if (stop | (acc & (defer ? bad : pend_valid & pend_halt))) halt <= 1'b1;
      if (defer & ~acc) pend_halt <= bad;
    end
  end
`else
  assign stop = 1'b0;
  assign halt = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench with an instruction-stream model for instr_fetch
module tb_instr_fetch;
  logic clk = 1'b0, rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0, imem_rsp_valid = 1'b0;
  logic [31:0] imem_req_addr, imem_rsp_data = 32'd0, jr_pc = 32'd0, pc_id, instr_id;
  logic stall = 1'b0, jump_branch = 1'b0, jump_target = 1'b0, jump_reg = 1'b0, valid_id;
`ifdef IFETCH_ALIGN_CHECK_EN
  logic fault_misaligned;
`endif
  always #5 clk = ~clk;

  instr_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .stall(stall), .jump_branch(jump_branch), .jump_target(jump_target), .jump_reg(jump_reg),
    .jr_pc(jr_pc), .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id)
`ifdef IFETCH_ALIGN_CHECK_EN
    , .fault_misaligned(fault_misaligned)
`endif
  );

  int tests = 0, fails = 0;
  logic [31:0] prog [logic [31:0]];
  int kind [logic [31:0]];
  logic [31:0] jrv [logic [31:0]];
  int cyc = 0, lat = 1, st_lo = 0, st_hi = -1, rdy_lo = 0, rdy_hi = -1, req_cnt = 0;
  bit lat_rand = 0, rdy_rand = 0, stall_rand = 0, stray = 0, rst_req = 1;
  bit mem_busy = 0;
  int mem_cnt = 0;
  logic [31:0] mem_addr = 32'd0;
  logic [31:0] exp_pc, tt, nxt, w, t, ph_a;
  logic [31:0] seen[$];
  bit tv, tpark, parked, pk, ph_v;
  int off;

  function automatic logic [31:0] word(input logic [31:0] a);
    return prog.exists(a) ? prog[a] : {16'h2400, a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_pc = 32'd0; tv = 0; tpark = 0; parked = 0; ph_v = 0;
    seen.delete();
  endtask

  task automatic clear_prog();
    prog.delete(); kind.delete(); jrv.delete();
    lat = 1; lat_rand = 0; rdy_rand = 0; stall_rand = 0; stray = 0;
    st_lo = 0; st_hi = -1; rdy_lo = 0; rdy_hi = -1;
  endtask

  task automatic cycle();
    @(negedge clk);
    rst = rst_req;
    cyc++;
    if (mem_busy && mem_cnt == 1) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = word(mem_addr); mem_busy = 0;
    end else begin
      if (mem_busy) mem_cnt--;
      imem_rsp_valid = stray; imem_rsp_data = 32'hDEAD_BEEF;
    end
    imem_req_ready = !(cyc >= rdy_lo && cyc <= rdy_hi) && (!rdy_rand || $urandom_range(1, 0) == 1);
    stall = (cyc >= st_lo && cyc <= st_hi) || (stall_rand && $urandom_range(3, 0) == 0);
    jump_branch = 1'b0; jump_target = 1'b0; jump_reg = 1'b0; jr_pc = $urandom;
    if (valid_id === 1'b1 && kind.exists(pc_id)) begin
      jump_branch = 1'b1;
      jump_target = kind[pc_id] == 2;
      jump_reg = kind[pc_id] == 3;
      if (kind[pc_id] == 3) jr_pc = jrv[pc_id];
    end
    #1;
    if (rst) mem_busy = 0;
    else if (imem_req_valid && imem_req_ready) begin
      mem_busy = 1; mem_cnt = lat_rand ? $urandom_range(3, 1) : lat; mem_addr = imem_req_addr;
    end
    if (!rst && imem_req_valid) req_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_reset();
    rst_req = 1;
    cycle();
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    cycle();
    chk("rst_req_valid2", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_valid_id", {31'd0, valid_id}, 32'd0);
    chk("rst_pc_id", pc_id, 32'd0);
    chk("rst_instr_id", instr_id, 32'd0);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("rst_fault", {31'd0, fault_misaligned}, 32'd0);
`endif
    model_reset();
    rst_req = 0;
    cyc = 0;
  endtask

  // expected instruction stream: sequential PCs, one delay slot, then the redirect target
  always @(negedge clk) begin
    #2;
    if (rst) ph_v = 0;
    else begin
      if (valid_id) chk("instr_id", instr_id, word(pc_id));
      else chk("nop_instr", instr_id, 32'd0);
      if (ph_v) begin
        chk("req_hold_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_hold_addr", imem_req_addr, ph_a);
      end
      if (imem_req_valid) chk("req_align", {30'd0, imem_req_addr[1:0]}, 32'd0);
      if (valid_id && !stall) begin
        if (parked) chk("consume_after_park", 32'd1, 32'd0);
        chk("pc_seq", pc_id, exp_pc);
        seen.push_back(pc_id);
        nxt = tv ? tt : pc_id + 32'd4;
        pk = tpark; tv = 0; tpark = 0;
        if (kind.exists(pc_id)) begin
          w = word(pc_id);
          if (kind[pc_id] == 1) begin
            off = $signed(w[15:0]);
            t = pc_id + 32'd4 + 32'(off * 4);
          end else if (kind[pc_id] == 2) t = ((pc_id + 32'd4) & 32'hF000_0000) | ((w & 32'h03FF_FFFF) * 4);
          else t = jrv[pc_id] & ~32'd3;
          tv = 1; tt = t;
`ifdef IFETCH_ALIGN_CHECK_EN
          if (kind[pc_id] == 3 && jrv[pc_id] % 4 != 0) begin tv = 0; tpark = 1; end
`endif
        end
        if (pk) parked = 1;
        exp_pc = nxt;
      end
      ph_v = imem_req_valid & ~imem_req_ready;
      ph_a = imem_req_addr;
    end
  end

  int rc;
  initial begin
    model_reset();
    // straight line then BEQ at 0x10, slot already issued
    clear_prog();
    prog[32'h10] = 32'h1000_0003; kind[32'h10] = 1;
    do_reset();
    cycle(); chk("c1_valid", {31'd0, imem_req_valid}, 32'd1); chk("c1_addr", imem_req_addr, 32'h0);
    cycle(); chk("c2_addr", imem_req_addr, 32'h4);
    cycle(); chk("c3_addr", imem_req_addr, 32'h8);
    chk("c3_valid_id", {31'd0, valid_id}, 32'd1); chk("c3_pc_id", pc_id, 32'h0);
    cycle(); chk("c4_addr", imem_req_addr, 32'hC);
    run(12);
    chk("beq_slot", seen[5], 32'h14); chk("beq_tgt", seen[6], 32'h20);
    // stall for 3 cycles while a response arrives
    st_lo = 4; st_hi = 6;
    do_reset();
    run(3);
    for (int i = 4; i <= 7; i++) begin
      cycle(); chk("stall_no_req", {31'd0, imem_req_valid}, 32'd0);
      if (i >= 5) chk("stall_pc_hold", pc_id, 32'h4);
    end
    cycle(); chk("stall_release_addr", imem_req_addr, 32'hC); chk("stall_release_pc", pc_id, 32'h8);
    run(12);
    chk("stall_seq3", seen[3], 32'hC); chk("stall_beq", seen[6], 32'h20);
    // BEQ reaching ID while its slot is still unrequested
    st_lo = 0; st_hi = -1; rdy_lo = 6; rdy_hi = 7;
    do_reset();
    run(8);
    chk("pend_valid", {31'd0, imem_req_valid}, 32'd1); chk("pend_slot_addr", imem_req_addr, 32'h14);
    cycle(); chk("pend_tgt_addr", imem_req_addr, 32'h20);
    run(8);
    chk("pend_slot", seen[5], 32'h14); chk("pend_tgt", seen[6], 32'h20);
    // J chain into 0x0040_0008 and back to 0x40
    clear_prog();
    prog[32'h8] = 32'h0810_0002; kind[32'h8] = 2;
    prog[32'h0040_0008] = 32'h0800_0010; kind[32'h0040_0008] = 2;
    do_reset();
    run(16);
    chk("j_far", seen[4], 32'h0040_0008); chk("j_slot", seen[5], 32'h0040_000C); chk("j_tgt", seen[6], 32'h40);
    // JR to a misaligned address
    clear_prog();
    prog[32'h8] = 32'h0100_0008; kind[32'h8] = 3; jrv[32'h8] = 32'h102;
    do_reset();
    run(12);
    rc = req_cnt;
    run(10);
`ifdef IFETCH_ALIGN_CHECK_EN
    chk("jr_fault", {31'd0, fault_misaligned}, 32'd1);
    chk("jr_parked_reqs", 32'(req_cnt - rc), 32'd0);
    chk("jr_seen", 32'(seen.size()), 32'd4);
`else
    chk("jr_slot", seen[3], 32'hC); chk("jr_tgt", seen[4], 32'h100);
`endif
    // random ready, latency and stall with jumps and loops
    clear_prog();
    prog[32'h18] = 32'h0100_0008; kind[32'h18] = 3; jrv[32'h18] = 32'h40;
    prog[32'h48] = 32'h1000_FFFD; kind[32'h48] = 1;
    prog[32'h40] = 32'h0800_0011; kind[32'h40] = 2;
    lat_rand = 1; rdy_rand = 1; stall_rand = 1;
    do_reset();
    run(400);
    chk("rand_progress", 32'(seen.size() > 40), 32'd1);
    // reset while a request is outstanding, stray responses around it
    clear_prog();
    lat = 3;
    do_reset();
    cycle();
    rst_req = 1; stray = 1;
    cycle();
    model_reset();
    rst_req = 0;
    cycle();
    chk("rr_valid", {31'd0, imem_req_valid}, 32'd1); chk("rr_addr", imem_req_addr, 32'h0);
    chk("rr_valid_id", {31'd0, valid_id}, 32'd0);
    stray = 0;
    run(14);
    chk("rr_first", seen[0], 32'h0); chk("rr_second", seen[1], 32'h4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
